// File: rtl/io_bus_arb.sv
// -----------------------------------------------------------------------------
// io_bus_arb
// Shares the internal I/O register bus between the AVR core and one auxiliary
// master (OCD/DMA). The core has priority. The aux master is granted idle bus
// slots, and it is also granted a forced slot after STARVE_LIM consecutive
// blocked request cycles. While the aux master owns the bus the core is
// stalled. Wait states from io_rdy stretch both core and aux accesses. An aux
// access that is still waiting after MAX_WAIT cycles ends with an error.
//
// Ports
//   cp2, ireset          clock (rising edge), asynchronous active-low reset
//   core_adr/iore/iowe   core I/O access request
//   core_dbusout         core write data
//   core_rdata           read data to the core (io_dbusin)
//   core_wait            core stall request (combinational)
//   aux_req              aux request; level, held until aux_gnt
//   aux_adr/we/wdata     aux access attributes, latched on grant
//   aux_gnt              one-cycle grant pulse (combinational)
//   aux_done, aux_err    completion pulse and its timeout qualifier (registered)
//   aux_rdata            aux read data, held until the next completion
//   io_adr/iore/iowe     I/O bus address and strobes
//   io_dbusout           I/O bus write data
//   io_dbusin, io_rdy    I/O bus read data and peripheral ready
// -----------------------------------------------------------------------------
module io_bus_arb #(
   parameter int ADR_W      = 6,
   parameter int DATA_W     = 8,
   parameter int STARVE_LIM = 4,
   parameter int MAX_WAIT   = 7
) (
   input  logic              cp2,
   input  logic              ireset,
   input  logic [ADR_W-1:0]  core_adr,
   input  logic              core_iore,
   input  logic              core_iowe,
   input  logic [DATA_W-1:0] core_dbusout,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_wait,
   input  logic              aux_req,
   input  logic [ADR_W-1:0]  aux_adr,
   input  logic              aux_we,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic              aux_done,
   output logic              aux_err,
   output logic [DATA_W-1:0] aux_rdata,
   output logic [ADR_W-1:0]  io_adr,
   output logic              io_iore,
   output logic              io_iowe,
   output logic [DATA_W-1:0] io_dbusout,
   input  logic [DATA_W-1:0] io_dbusin,
   input  logic              io_rdy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_AUX  = 1'b1;

   // Counters only need to reach LIM-1, so width is clog2(LIM), at least 1.
   localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM - 1);
   localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT - 1);

   logic [0:0]        state_q,  state_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [WW-1:0]     wait_q,   wait_d;
   logic [ADR_W-1:0]  adr_q,    adr_d;
   logic              we_q,     we_d;
   logic [DATA_W-1:0] wdata_q,  wdata_d;
   logic              done_q,   done_d;
   logic              err_q,    err_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic              core_busy;

   assign core_busy  = core_iore | core_iowe;
   assign core_rdata = io_dbusin;
   assign aux_done   = done_q;
   assign aux_err    = err_q;
   assign aux_rdata  = rdata_q;

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      wait_d     = wait_q;
      adr_d      = adr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      err_d      = err_q;
      rdata_d    = rdata_q;
      aux_gnt    = 1'b0;
      core_wait  = 1'b0;
      io_adr     = core_adr;
      io_dbusout = core_dbusout;
      io_iore    = core_iore;
      io_iowe    = core_iowe;

      case (state_q)
         ST_IDLE: begin
            core_wait = core_busy & ~io_rdy;
            if (aux_req && (!core_busy || starve_q == STARVE_MAX)) begin
               aux_gnt  = 1'b1;
               adr_d    = aux_adr;
               we_d     = aux_we;
               wdata_d  = aux_wdata;
               starve_d = '0;
               state_d  = ST_AUX;
               // Forced slot: core access is suppressed and retried after.
               if (core_busy) begin
                  core_wait = 1'b1;
                  io_iore   = 1'b0;
                  io_iowe   = 1'b0;
               end
            end else if (aux_req) begin
               // Reaching here with aux_req implies core busy and below limit.
               starve_d = starve_q + SW'(1);
            end else begin
               starve_d = '0;
            end
         end
         ST_AUX: begin
            io_adr     = adr_q;
            io_dbusout = wdata_q;
            io_iore    = ~we_q;
            io_iowe    = we_q;
            core_wait  = core_busy;
            starve_d   = '0;
            if (io_rdy) begin
               done_d  = 1'b1;
               err_d   = 1'b0;
               if (!we_q) rdata_d = io_dbusin;
               wait_d  = '0;
               state_d = ST_IDLE;
            end else if (wait_q == WAIT_MAX) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               if (!we_q) rdata_d = '1;
               wait_d  = '0;
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
         wait_q   <= '0;
         adr_q    <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         wait_q   <= wait_d;
         adr_q    <= adr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_io_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arb
// Directed per-cycle vectors for io_bus_arb (STARVE_LIM=4, MAX_WAIT=7): each
// record gives the inputs for one clock cycle and the outputs expected in that
// cycle. A hand-written sequence covers reset during an aux access.
// -----------------------------------------------------------------------------
module tb_io_bus_arb;

   logic       cp2 = 1'b0;
   logic       ireset;
   logic [5:0] core_adr;
   logic       core_iore, core_iowe;
   logic [7:0] core_dbusout, core_rdata;
   logic       core_wait;
   logic       aux_req;
   logic [5:0] aux_adr;
   logic       aux_we;
   logic [7:0] aux_wdata;
   logic       aux_gnt, aux_done, aux_err;
   logic [7:0] aux_rdata;
   logic [5:0] io_adr;
   logic       io_iore, io_iowe;
   logic [7:0] io_dbusout, io_dbusin;
   logic       io_rdy;

   int checks = 0;
   int errors = 0;

   io_bus_arb #(.ADR_W(6), .DATA_W(8), .STARVE_LIM(4), .MAX_WAIT(7)) dut (
      .cp2(cp2), .ireset(ireset),
      .core_adr(core_adr), .core_iore(core_iore), .core_iowe(core_iowe),
      .core_dbusout(core_dbusout), .core_rdata(core_rdata), .core_wait(core_wait),
      .aux_req(aux_req), .aux_adr(aux_adr), .aux_we(aux_we), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_done(aux_done), .aux_err(aux_err), .aux_rdata(aux_rdata),
      .io_adr(io_adr), .io_iore(io_iore), .io_iowe(io_iowe), .io_dbusout(io_dbusout),
      .io_dbusin(io_dbusin), .io_rdy(io_rdy)
   );

   always #5 cp2 = ~cp2;

   typedef struct {
      logic       cre, cwe;
      logic [5:0] cadr;
      logic [7:0] cdo;
      logic       areq, awe;
      logic [5:0] aadr;
      logic [7:0] awd;
      logic [7:0] din;
      logic       rdy;
      logic       x_wait, x_gnt, x_done, x_err;
      logic [7:0] x_rdata;
      logic [5:0] x_adr;
      logic       x_iore, x_iowe;
      logic [7:0] x_do;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      core_adr = '0; core_iore = 1'b0; core_iowe = 1'b0; core_dbusout = '0;
      aux_req = 1'b0; aux_adr = '0; aux_we = 1'b0; aux_wdata = '0;
      io_dbusin = '0; io_rdy = 1'b1;
   endtask

   initial begin
      // cre cwe cadr cdo | areq awe aadr awd | din rdy | wait gnt done err rdata | adr iore iowe do
      // T2: idle-slot aux read of 3F, data A5
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,6'h3F,8'h00, 8'hA5,1'b1, 1'b0,1'b1,1'b0,1'b0,8'h00, 6'h00,1'b0,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'hA5,1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00, 6'h3F,1'b1,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b1,1'b0,8'hA5, 6'h00,1'b0,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'hA5, 6'h00,1'b0,1'b0,8'h00});
      // T6: core write with two wait states
      tbl.push_back('{1'b0,1'b1,6'h10,8'h55, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b0, 1'b1,1'b0,1'b0,1'b0,8'hA5, 6'h10,1'b0,1'b1,8'h55});
      tbl.push_back('{1'b0,1'b1,6'h10,8'h55, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b0, 1'b1,1'b0,1'b0,1'b0,8'hA5, 6'h10,1'b0,1'b1,8'h55});
      tbl.push_back('{1'b0,1'b1,6'h10,8'h55, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'hA5, 6'h10,1'b0,1'b1,8'h55});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'hA5, 6'h00,1'b0,1'b0,8'h00});
      // T4: aux write 3D<=12, three wait states, core stalled while it reads
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b1,1'b1,6'h3D,8'h12, 8'h00,1'b1, 1'b0,1'b1,1'b0,1'b0,8'hA5, 6'h00,1'b0,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'hA5, 6'h3D,1'b0,1'b1,8'h12});
      tbl.push_back('{1'b1,1'b0,6'h22,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b0, 1'b1,1'b0,1'b0,1'b0,8'hA5, 6'h3D,1'b0,1'b1,8'h12});
      tbl.push_back('{1'b1,1'b0,6'h22,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b0, 1'b1,1'b0,1'b0,1'b0,8'hA5, 6'h3D,1'b0,1'b1,8'h12});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'hA5, 6'h3D,1'b0,1'b1,8'h12});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b1,1'b0,8'hA5, 6'h00,1'b0,1'b0,8'h00});
      // T5: aux read of 05 times out after 7 bus cycles
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,6'h05,8'h9C, 8'h00,1'b1, 1'b0,1'b1,1'b0,1'b0,8'hA5, 6'h00,1'b0,1'b0,8'h00});
      for (int k = 0; k < 7; k++)
         tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h77,1'b0, 1'b0,1'b0,1'b0,1'b0,8'hA5, 6'h05,1'b1,1'b0,8'h9C});
      // done+err cycle doubles as a back-to-back re-request (read of 01)
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b1,1'b0,6'h01,8'h00, 8'h00,1'b1, 1'b0,1'b1,1'b1,1'b1,8'hFF, 6'h00,1'b0,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h3C,1'b1, 1'b0,1'b0,1'b0,1'b1,8'hFF, 6'h01,1'b1,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b1,1'b0,8'h3C, 6'h00,1'b0,1'b0,8'h00});
      // T3: core reads every cycle; aux write 2A<=E7 forced on 4th blocked cycle
      for (int k = 0; k < 3; k++)
         tbl.push_back('{1'b1,1'b0,6'h08,8'h00, 1'b1,1'b1,6'h2A,8'hE7, 8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'h3C, 6'h08,1'b1,1'b0,8'h00});
      tbl.push_back('{1'b1,1'b0,6'h08,8'h00, 1'b1,1'b1,6'h2A,8'hE7, 8'h00,1'b1, 1'b1,1'b1,1'b0,1'b0,8'h3C, 6'h08,1'b0,1'b0,8'h00});
      tbl.push_back('{1'b1,1'b0,6'h08,8'h00, 1'b1,1'b1,6'h2A,8'hE7, 8'h00,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h3C, 6'h2A,1'b0,1'b1,8'hE7});
      tbl.push_back('{1'b1,1'b0,6'h08,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b1,1'b0,8'h3C, 6'h08,1'b1,1'b0,8'h00});
      tbl.push_back('{1'b0,1'b0,6'h00,8'h00, 1'b0,1'b0,6'h00,8'h00, 8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'h3C, 6'h00,1'b0,1'b0,8'h00});

      // Reset state
      ireset = 1'b0;
      idle_inputs();
      #1;
      chk("reset_regs", 0, {29'd0, aux_done, aux_err, core_wait}, 32'd0);
      chk("reset_rdata", 0, {24'd0, aux_rdata}, 32'd0);
      chk("reset_bus", 0, {28'd0, io_iore, io_iowe, aux_gnt, 1'b0}, 32'd0);
      @(negedge cp2);
      @(negedge cp2);
      ireset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge cp2);
         core_iore = tbl[i].cre;  core_iowe = tbl[i].cwe;
         core_adr = tbl[i].cadr;  core_dbusout = tbl[i].cdo;
         aux_req = tbl[i].areq;   aux_we = tbl[i].awe;
         aux_adr = tbl[i].aadr;   aux_wdata = tbl[i].awd;
         io_dbusin = tbl[i].din;  io_rdy = tbl[i].rdy;
         #1;
         chk("vec", i,
             {4'd0, core_wait, aux_gnt, aux_done, aux_err, aux_rdata, io_adr,
              io_iore, io_iowe, io_dbusout},
             {4'd0, tbl[i].x_wait, tbl[i].x_gnt, tbl[i].x_done, tbl[i].x_err,
              tbl[i].x_rdata, tbl[i].x_adr, tbl[i].x_iore, tbl[i].x_iowe, tbl[i].x_do});
         chk("core_rdata", i, {24'd0, core_rdata}, {24'd0, tbl[i].din});
      end

      // T1: reset asserted in the middle of a stalled aux read
      @(negedge cp2);
      idle_inputs();
      aux_req = 1'b1; aux_adr = 6'h11; io_rdy = 1'b0;
      #1;
      chk("t1_gnt", 0, {31'd0, aux_gnt}, 32'd1);
      @(negedge cp2);
      aux_req = 1'b0;
      #1;
      chk("t1_busy", 0, {26'd0, io_adr}, {26'd0, 6'h11});
      chk("t1_iore", 0, {31'd0, io_iore}, 32'd1);
      ireset = 1'b0;
      #1;
      chk("t1_rst_bus", 0, {24'd0, io_adr, io_iore, io_iowe}, 32'd0);
      chk("t1_rst_out", 0, {23'd0, aux_done, aux_rdata}, 32'd0);
      @(negedge cp2);
      ireset = 1'b1;
      io_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge cp2);
         #1;
         chk("t1_no_done", k, {29'd0, aux_done, io_iore, io_iowe}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
